// File: rtl/stream_bus_pkg.sv
// Purpose: shared register map, field positions and counter widths for the stream-to-bus FIFO bridge.
// Latency: n/a (constants only).
// Backpressure: n/a.
package stream_bus_pkg;

    // Register indices on the 2-bit host address bus
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_IRQ    = 2'd3;

    // DATA: bit 31 flags that a real word was popped
    localparam int DATA_VLD_BIT    = 31;

    // STATUS: level sits at [ADDR_WIDTH:0], drop count above it
    localparam int STATUS_DROP_LSB = 16;
    localparam int STATUS_OVF_BIT  = 31;

    // CTRL: threshold sits at [ADDR_WIDTH:0]
    localparam int CTRL_THR_EN_BIT = 30;
    localparam int CTRL_OVF_EN_BIT = 31;

    // IRQ: pending bits, write-one-to-clear
    localparam int IRQ_THR_BIT     = 0;
    localparam int IRQ_OVF_BIT     = 1;

    // Saturating drop counter
    localparam int                DROP_W   = 15;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;
    localparam logic [DROP_W-1:0] DROP_ONE = 1;

endpackage

// File: rtl/sync_fifo.sv
// Purpose: circular FIFO (simple dual-port RAM, pointers, level counter) for the bus bridge.
// Latency: word written on push edge; rd_data_o is the RAM output register, loaded on the pop edge.
// Backpressure: caller must only push when !full_o and only pop when !empty_o.
// Ports: clk/rst, push_i + wr_data_i, pop_i, rd_data_o (head word captured at pop), level_o, full_o, empty_o.
module sync_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 2048,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [AW:0]      level_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [AW:0]   LVL_ONE  = 1;
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q, level_d;

    // RAM: no reset on storage or output register so it maps onto block RAM.
    // Read and write addresses never collide: a push needs !full, so the
    // slot at wr_ptr is never the live head being read.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem[wr_ptr_q] <= wr_data_i;
        end
        if (pop_i) begin
            rd_data_q <= mem[rd_ptr_q];
        end
    end

    // Simultaneous push and pop leaves the level unchanged.
    always_comb begin
        level_d = level_q;
        case ({push_i, pop_i})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            level_q <= level_d;
        end
    end

    assign rd_data_o = rd_data_q;
    assign level_o   = level_q;
    assign full_o    = (level_q == LVL_FULL);
    assign empty_o   = (level_q == '0);

endmodule

// File: rtl/stream_bus_fifo.sv
// Purpose: ready/valid stream into a FIFO, drained by host reads of a pop-on-read DATA register, with CSRs and irq.
// Latency: read_data valid one edge after the read strobe; pushed word readable from the next cycle.
// Backpressure: source_ready drops when the FIFO is full; words offered while full are dropped and counted.
// Ports: clk/rst, host bus (chipselect, address, read, write, write_data, read_data), stream (source_*), irq.
module stream_bus_fifo
    import stream_bus_pkg::*;
#(
    parameter int DATA_SIZE  = 28,
    parameter int DEPTH      = 2048,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 chipselect,
    input  logic [1:0]           address,
    input  logic                 read,
    input  logic                 write,
    input  logic [31:0]          write_data,
    output logic [31:0]          read_data,
    input  logic                 source_valid,
    input  logic [DATA_SIZE-1:0] source_data,
    output logic                 source_ready,
    output logic                 irq
);

    logic                  fifo_full, fifo_empty;
    logic [ADDR_WIDTH:0]   level;
    logic [DATA_SIZE-1:0]  fifo_rd_data;
    logic                  push, drop, pop, bus_rd, bus_wr, clr_thr, clr_ovf, thr_hit;
    logic [31:0]           fifo_word, status_word, ctrl_word, irq_word;

    logic [ADDR_WIDTH:0]   thr_q, thr_d;
    logic                  thr_en_q, thr_en_d, ovf_en_q, ovf_en_d;
    logic                  thr_pend_q, thr_pend_d, ovf_pend_q, ovf_pend_d;
    logic                  ovf_flag_q, ovf_flag_d, irq_q, irq_d;
    logic [DROP_W-1:0]     drop_q, drop_d;
    logic                  rd_sel_q, rd_sel_d;
    logic [31:0]           rd_reg_q, rd_reg_d;

    assign source_ready = !fifo_full;
    assign push    = source_valid && source_ready;
    assign drop    = source_valid && !source_ready;
    assign bus_rd  = chipselect && read;
    assign bus_wr  = chipselect && write;
    assign pop     = bus_rd && (address == REG_DATA) && !fifo_empty;
    assign clr_thr = bus_wr && (address == REG_IRQ) && write_data[IRQ_THR_BIT];
    assign clr_ovf = bus_wr && (address == REG_IRQ) && write_data[IRQ_OVF_BIT];
    assign thr_hit = (thr_q != '0) && (level >= thr_q);

    sync_fifo #(
        .WIDTH (DATA_SIZE),
        .DEPTH (DEPTH),
        .AW    (ADDR_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push),
        .wr_data_i (source_data),
        .pop_i     (pop),
        .rd_data_o (fifo_rd_data),
        .level_o   (level),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    always_comb begin
        fifo_word = '0;
        fifo_word[DATA_SIZE-1:0]  = fifo_rd_data;
        fifo_word[DATA_VLD_BIT]   = 1'b1;

        status_word = '0;
        status_word[ADDR_WIDTH:0]                 = level;
        status_word[STATUS_DROP_LSB +: DROP_W]    = drop_q;
        status_word[STATUS_OVF_BIT]               = ovf_flag_q;

        ctrl_word = '0;
        ctrl_word[ADDR_WIDTH:0]    = thr_q;
        ctrl_word[CTRL_THR_EN_BIT] = thr_en_q;
        ctrl_word[CTRL_OVF_EN_BIT] = ovf_en_q;

        irq_word = '0;
        irq_word[IRQ_THR_BIT] = thr_pend_q;
        irq_word[IRQ_OVF_BIT] = ovf_pend_q;
    end

    always_comb begin
        thr_d      = thr_q;
        thr_en_d   = thr_en_q;
        ovf_en_d   = ovf_en_q;
        drop_d     = drop_q;
        rd_sel_d   = rd_sel_q;
        rd_reg_d   = rd_reg_q;

        if (bus_wr && (address == REG_CTRL)) begin
            thr_d    = write_data[ADDR_WIDTH:0];
            thr_en_d = write_data[CTRL_THR_EN_BIT];
            ovf_en_d = write_data[CTRL_OVF_EN_BIT];
        end

        // Set wins over clear so a condition still present on the clear cycle re-arms.
        thr_pend_d = (thr_pend_q && !clr_thr) || thr_hit;
        ovf_pend_d = (ovf_pend_q && !clr_ovf) || drop;
        ovf_flag_d = (ovf_flag_q && !clr_ovf) || drop;

        if (clr_ovf) begin
            drop_d = '0;
        end
        if (drop && (drop_d != DROP_MAX)) begin
            drop_d = drop_d + DROP_ONE;
        end

        irq_d = (thr_pend_q && thr_en_q) || (ovf_pend_q && ovf_en_q);

        // A DATA pop presents the RAM output register directly; every other
        // read is snapshotted into rd_reg_q. Both are registered sources.
        if (bus_rd) begin
            rd_sel_d = 1'b0;
            case (address)
                REG_DATA: begin
                    rd_sel_d = !fifo_empty;
                    rd_reg_d = '0;
                end
                REG_STATUS: rd_reg_d = status_word;
                REG_CTRL:   rd_reg_d = ctrl_word;
                REG_IRQ:    rd_reg_d = irq_word;
                default:    rd_reg_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thr_q      <= '0;
            thr_en_q   <= 1'b0;
            ovf_en_q   <= 1'b0;
            thr_pend_q <= 1'b0;
            ovf_pend_q <= 1'b0;
            ovf_flag_q <= 1'b0;
            drop_q     <= '0;
            irq_q      <= 1'b0;
            rd_sel_q   <= 1'b0;
            rd_reg_q   <= '0;
        end else begin
            thr_q      <= thr_d;
            thr_en_q   <= thr_en_d;
            ovf_en_q   <= ovf_en_d;
            thr_pend_q <= thr_pend_d;
            ovf_pend_q <= ovf_pend_d;
            ovf_flag_q <= ovf_flag_d;
            drop_q     <= drop_d;
            irq_q      <= irq_d;
            rd_sel_q   <= rd_sel_d;
            rd_reg_q   <= rd_reg_d;
        end
    end

    assign read_data = rd_sel_q ? fifo_word : rd_reg_q;
    assign irq       = irq_q;

    // Only a few write_data bits are meaningful for any given register.
    logic unused_wdata;
    assign unused_wdata = ^write_data;

endmodule

// File: tb/tb_stream_bus_fifo.sv
module tb_stream_bus_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance A: default 28-bit x 2048
    logic        cs_a, rd_a, wr_a, sv_a, sr_a, irq_a;
    logic [1:0]  addr_a;
    logic [31:0] wdat_a, rdat_a;
    logic [27:0] sd_a;

    // Instance B: 16-bit x 8
    logic        cs_b, rd_b, wr_b, sv_b, sr_b, irq_b;
    logic [1:0]  addr_b;
    logic [31:0] wdat_b, rdat_b;
    logic [15:0] sd_b;

    stream_bus_fifo u_dut_a (
        .clk(clk), .rst(rst), .chipselect(cs_a), .address(addr_a), .read(rd_a),
        .write(wr_a), .write_data(wdat_a), .read_data(rdat_a), .source_valid(sv_a),
        .source_data(sd_a), .source_ready(sr_a), .irq(irq_a)
    );

    stream_bus_fifo #(.DATA_SIZE(16), .DEPTH(8)) u_dut_b (
        .clk(clk), .rst(rst), .chipselect(cs_b), .address(addr_b), .read(rd_b),
        .write(wr_b), .write_data(wdat_b), .read_data(rdat_b), .source_valid(sv_b),
        .source_data(sd_b), .source_ready(sr_b), .irq(irq_b)
    );

    localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_CTRL = 2'd2, A_IRQ = 2'd3;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_a [$];
    logic [31:0] exp_b [$];
    logic [31:0] e_a, e_b;
    logic        rd_seen_a = 1'b0;
    logic        rd_seen_b = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: a bus read strobed at one edge is compared at the following negedge.
    always @(posedge clk) begin
        rd_seen_a <= cs_a && rd_a;
        rd_seen_b <= cs_b && rd_b;
    end

    always @(negedge clk) begin
        if (rd_seen_a) begin
            if (exp_a.size() == 0) begin
                total++; bad++;
                $display("FAIL rd_a: got 0x%08h, want no read", rdat_a);
            end else begin
                e_a = exp_a.pop_front();
                check("rd_a", rdat_a, e_a);
            end
        end
        if (rd_seen_b) begin
            if (exp_b.size() == 0) begin
                total++; bad++;
                $display("FAIL rd_b: got 0x%08h, want no read", rdat_b);
            end else begin
                e_b = exp_b.pop_front();
                check("rd_b", rdat_b, e_b);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_read_a(input logic [1:0] a, input logic [31:0] e);
        cs_a = 1'b1; rd_a = 1'b1; addr_a = a;
        exp_a.push_back(e);
        tick();
        cs_a = 1'b0; rd_a = 1'b0;
    endtask

    task automatic bus_write_a(input logic [1:0] a, input logic [31:0] d);
        cs_a = 1'b1; wr_a = 1'b1; addr_a = a; wdat_a = d;
        tick();
        cs_a = 1'b0; wr_a = 1'b0;
    endtask

    task automatic push_word_a(input logic [27:0] d);
        sv_a = 1'b1; sd_a = d;
        tick();
        sv_a = 1'b0;
    endtask

    task automatic bus_read_b(input logic [1:0] a, input logic [31:0] e);
        cs_b = 1'b1; rd_b = 1'b1; addr_b = a;
        exp_b.push_back(e);
        tick();
        cs_b = 1'b0; rd_b = 1'b0;
    endtask

    initial begin
        cs_a = 0; rd_a = 0; wr_a = 0; addr_a = 0; wdat_a = 0; sv_a = 0; sd_a = 0;
        cs_b = 0; rd_b = 0; wr_b = 0; addr_b = 0; wdat_b = 0; sv_b = 0; sd_b = 0;
        rst = 1'b1;
        tick();
        tick();
        check("rst_rdata_a", rdat_a, 32'h0);
        check("rst_ready_a", 32'(sr_a), 32'h1);
        check("rst_irq_a",   32'(irq_a), 32'h0);
        check("rst_ready_b", 32'(sr_b), 32'h1);
        rst = 1'b0;

        // Basic push / pop, then read of an empty FIFO
        push_word_a(28'h1);
        push_word_a(28'h2);
        push_word_a(28'h3);
        bus_read_a(A_DATA, 32'h8000_0001);
        bus_read_a(A_DATA, 32'h8000_0002);
        bus_read_a(A_DATA, 32'h8000_0003);
        bus_read_a(A_DATA, 32'h0000_0000);
        bus_read_a(A_STATUS, 32'h0000_0000);

        // Fill to DEPTH, then 5 dropped words with the overflow interrupt enabled
        bus_write_a(A_CTRL, 32'h8000_0000);
        sv_a = 1'b1;
        for (int i = 0; i < 2053; i++) begin
            sd_a = 28'(i);
            if (i == 2047) check("ready_before_full", 32'(sr_a), 32'h1);
            if (i == 2048) begin
                check("ready_at_full", 32'(sr_a), 32'h0);
                check("irq_before_drop", 32'(irq_a), 32'h0);
            end
            tick();
        end
        sv_a = 1'b0;
        check("irq_ovf", 32'(irq_a), 32'h1);
        bus_read_a(A_STATUS, 32'h8005_0800);
        bus_read_a(A_IRQ, 32'h0000_0002);
        bus_write_a(A_IRQ, 32'h0000_0002);
        tick();
        check("irq_ovf_cleared", 32'(irq_a), 32'h0);
        bus_read_a(A_STATUS, 32'h0000_0800);

        // Pop while full: ready must stay low this cycle; then push+pop at DEPTH-1
        cs_a = 1'b1; rd_a = 1'b1; addr_a = A_DATA;
        exp_a.push_back(32'h8000_0000);
        check("full_pop_ready", 32'(sr_a), 32'h0);
        tick();
        for (int k = 1; k <= 10; k++) begin
            sv_a = 1'b1;
            sd_a = 28'(32'hA000 + k);
            exp_a.push_back(32'h8000_0000 | k);
            if (k == 1) check("ready_at_depth_m1", 32'(sr_a), 32'h1);
            tick();
        end
        sv_a = 1'b0; cs_a = 1'b0; rd_a = 1'b0;
        bus_read_a(A_STATUS, 32'h0000_07FF);
        for (int k = 11; k < 2048; k++) bus_read_a(A_DATA, 32'h8000_0000 | k);
        for (int k = 1; k <= 10; k++) bus_read_a(A_DATA, 32'h8000_A000 + k);
        bus_read_a(A_DATA, 32'h0000_0000);
        bus_read_a(A_STATUS, 32'h0000_0000);

        // Threshold interrupt
        bus_write_a(A_CTRL, 32'h4000_0004);
        push_word_a(28'h11);
        push_word_a(28'h12);
        push_word_a(28'h13);
        push_word_a(28'h14);
        check("thr_irq_early0", 32'(irq_a), 32'h0);
        tick();
        check("thr_irq_early1", 32'(irq_a), 32'h0);
        tick();
        check("thr_irq_set", 32'(irq_a), 32'h1);
        bus_write_a(A_IRQ, 32'h0000_0001);
        bus_read_a(A_IRQ, 32'h0000_0001);
        check("thr_irq_rearmed", 32'(irq_a), 32'h1);
        bus_read_a(A_DATA, 32'h8000_0011);
        bus_write_a(A_IRQ, 32'h0000_0001);
        tick();
        check("thr_irq_cleared", 32'(irq_a), 32'h0);
        bus_read_a(A_IRQ, 32'h0000_0000);
        check("thr_irq_stays0", 32'(irq_a), 32'h0);

        // Async reset between edges mid-burst
        bus_write_a(A_CTRL, 32'h4000_0001);
        tick();
        tick();
        check("pre_rst_irq", 32'(irq_a), 32'h1);
        bus_read_a(A_STATUS, 32'h0000_0003);
        sv_a = 1'b1; sd_a = 28'h31;
        tick();
        sd_a = 28'h32;
        tick();
        #3;
        rst = 1'b1;
        #1;
        check("arst_rdata", rdat_a, 32'h0);
        check("arst_irq",   32'(irq_a), 32'h0);
        check("arst_ready", 32'(sr_a), 32'h1);
        sv_a = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        bus_read_a(A_DATA, 32'h0000_0000);
        bus_read_a(A_STATUS, 32'h0000_0000);
        push_word_a(28'h55);
        bus_read_a(A_DATA, 32'h8000_0055);
        bus_read_a(A_IRQ, 32'h0000_0000);
        check("post_rst_irq", 32'(irq_a), 32'h0);

        // Small instance: fill with 0xFFFF, ninth word dropped
        sv_b = 1'b1; sd_b = 16'hFFFF;
        for (int i = 0; i < 9; i++) begin
            if (i == 7) check("b_ready_before_full", 32'(sr_b), 32'h1);
            if (i == 8) check("b_ready_full", 32'(sr_b), 32'h0);
            tick();
        end
        sv_b = 1'b0;
        bus_read_b(A_STATUS, 32'h8001_0008);
        for (int i = 0; i < 8; i++) bus_read_b(A_DATA, 32'h8000_FFFF);
        bus_read_b(A_DATA, 32'h0000_0000);

        tick();
        tick();
        check("queue_a_drained", 32'(exp_a.size()), 32'h0);
        check("queue_b_drained", 32'(exp_b.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
